// File: rtl/spi_controller.sv
// rtl/spi_controller.sv - SPI mode-0 initiator sending one FRAME_BITS frame per handshake
// MSB first; cipo is captured into rx_data and presented with a one-cycle rx_valid at frame end.
module spi_controller #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int CS_GAP     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [FRAME_BITS-1:0] tx_data,
  output logic [FRAME_BITS-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  ncs,
  output logic                  sclk,
  output logic                  copi,
  input  logic                  cipo
);

  localparam int CS_MAX = (CS_SETUP > CS_HOLD) ? ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP)
                                               : ((CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP);
  localparam int PH_W  = (CS_MAX > 1) ? $clog2(CS_MAX) : 1;
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS);

  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);
  localparam logic [PH_W-1:0]  GAP_LAST   = PH_W'(CS_GAP - 1);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(FRAME_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  state_t state, state_next;

  logic [PH_W-1:0]       ph_cnt;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_shift;
  logic                  div_tc;
  logic                  last_fall;

  assign div_tc    = (div_cnt == DIV_LAST);
  assign last_fall = div_tc && sclk && (bit_cnt == BIT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tx_valid && tx_ready)   state_next = SETUP;
      SETUP:   if (ph_cnt == SETUP_LAST)   state_next = SHIFT;
      SHIFT:   if (last_fall)              state_next = HOLD;
      HOLD:    if (ph_cnt == HOLD_LAST)    state_next = GAP;
      GAP:     if (ph_cnt == GAP_LAST)     state_next = IDLE;
      default:                             state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_ready <= 1'b0;
      busy     <= 1'b0;
      rx_valid <= 1'b0;
      rx_data  <= '0;
      ncs      <= 1'b1;
      sclk     <= 1'b0;
      copi     <= 1'b0;
      ph_cnt   <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
    end else begin
      rx_valid <= 1'b0;
      tx_ready <= (state_next == IDLE);
      busy     <= (state_next != IDLE);

      if (state_next != state) begin
        ph_cnt <= '0;
      end else if (state == SETUP || state == HOLD || state == GAP) begin
        ph_cnt <= ph_cnt + PH_W'(1);
      end

      case (state)
        IDLE: begin
          if (state_next == SETUP) begin
            // copi carries the MSB from here on; tx_shift keeps the bits still to come.
            copi     <= tx_data[FRAME_BITS-1];
            tx_shift <= {tx_data[FRAME_BITS-2:0], 1'b0};
            ncs      <= 1'b0;
            rx_shift <= '0;
            bit_cnt  <= '0;
            div_cnt  <= '0;
          end
        end
        SHIFT: begin
          if (div_tc) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (!sclk) begin
              rx_shift <= {rx_shift[FRAME_BITS-2:0], cipo};
            end else if (!last_fall) begin
              bit_cnt  <= bit_cnt + BIT_W'(1);
              copi     <= tx_shift[FRAME_BITS-1];
              tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
            end
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end
        HOLD: begin
          if (state_next == GAP) begin
            ncs      <= 1'b1;
            copi     <= 1'b0;
            rx_data  <= rx_shift;
            rx_valid <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_controller.sv
// tb/tb_spi_controller.sv - self-checking bench for spi_controller
// Frame-level monitor plus table/random vectors and hand-written corner sequences.
module tb_spi_controller;

  localparam int CD = 4, FB = 16, SU = 2, HD = 2, GP = 4;
  localparam int LOW_T = SU + 2 * CD * FB + HD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        tx_valid = 1'b0;
  logic [15:0] tx_data = 16'h0;
  logic        tx_ready, rx_valid, busy, ncs, sclk, copi, cipo;
  logic [15:0] rx_data;

  logic        tx_valid2 = 1'b0;
  logic [15:0] tx_data2 = 16'h0;
  logic        tx_ready2, rx_valid2, busy2, ncs2, sclk2, copi2, cipo2;
  logic [15:0] rx_data2;

  // Peripheral model: presents pat MSB first, advancing after each observed sclk rise.
  logic        cipo_sel = 1'b0;
  logic [15:0] pat = 16'h0;
  int          rises = 0;
  assign cipo  = cipo_sel ? ((rises < 16) ? pat[4'(15 - rises)] : 1'b0) : copi;
  assign cipo2 = copi2;

  spi_controller dut (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .ncs(ncs), .sclk(sclk),
    .copi(copi), .cipo(cipo)
  );

  spi_controller #(.CLK_DIV(2), .FRAME_BITS(16), .CS_SETUP(1), .CS_HOLD(1), .CS_GAP(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .tx_valid(tx_valid2), .tx_ready(tx_ready2), .tx_data(tx_data2),
    .rx_data(rx_data2), .rx_valid(rx_valid2), .busy(busy2), .ncs(ncs2), .sclk(sclk2),
    .copi(copi2), .cipo(cipo2)
  );

  typedef struct {
    int          low;
    int          rises;
    logic [15:0] bits;
    logic        phase_bad;
    logic        rxv;
  } frame_t;

  typedef struct {
    logic [15:0] tx;
    logic        sel;
    logic [15:0] word;
    logic [15:0] exp_rx;
  } vec_t;

  frame_t      frame_q[$];
  logic [15:0] rx_q[$];
  int          gap_q[$];
  int          checks = 0;
  int          errors = 0;

  logic        prev_ncs = 1'b1, prev_sclk = 1'b0, phase_bad = 1'b0;
  int          cur_low = 0, high_run = 0, run = 0, txr_bad = 0;
  logic [15:0] copi_bits = 16'h0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ncs = 1'b1; prev_sclk = 1'b0; run = 0; rises = 0; high_run = 0;
    end else begin
      if (!ncs && prev_ncs) begin
        gap_q.push_back(high_run);
        cur_low = 0; rises = 0; copi_bits = 16'h0; run = 0; phase_bad = 1'b0;
      end
      if (ncs && !prev_ncs) begin
        frame_q.push_back('{cur_low, rises, copi_bits, phase_bad, rx_valid});
        high_run = 0;
      end
      if (!ncs) cur_low++;
      else high_run++;
      if (sclk != prev_sclk) begin
        if (rises > 0 && run != CD) phase_bad = 1'b1;
        run = 1;
        if (sclk) begin
          rises++;
          copi_bits = {copi_bits[14:0], copi};
        end
      end else begin
        run++;
      end
      if (rx_valid) rx_q.push_back(rx_data);
      if (tx_ready && (busy || !ncs)) txr_bad++;
      prev_ncs = ncs; prev_sclk = sclk;
    end
  end

  logic        p_ncs2 = 1'b1, p_sclk2 = 1'b0;
  logic [15:0] per_sh = 16'h0;
  logic [7:0]  per_upper = 8'h0, per_lower = 8'h0;
  int          low2 = 0, low2_last = 0, done2 = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      p_ncs2 = 1'b1; p_sclk2 = 1'b0; low2 = 0;
    end else begin
      if (!ncs2) begin
        if (p_ncs2) low2 = 0;
        low2++;
      end
      if (!ncs2 && sclk2 && !p_sclk2) per_sh = {per_sh[14:0], copi2};
      if (ncs2 && !p_ncs2) begin
        per_upper = per_sh[15:8]; per_lower = per_sh[7:0]; low2_last = low2; done2++;
      end
      p_ncs2 = ncs2; p_sclk2 = sclk2;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic wait_ready(input string name);
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(tx_ready), 32'd1);
  endtask

  task automatic send(input logic [15:0] d);
    wait_ready("ready_wait");
    tx_data = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data = 16'($urandom);
  endtask

  task automatic wait_frame(input int n, output bit ok);
    int k;
    k = 0;
    while (frame_q.size() < n && k < 2000) begin
      @(negedge clk);
      k++;
    end
    ok = (frame_q.size() >= n);
    check("frame_arrived", 32'(ok), 32'd1);
  endtask

  task automatic wait_rises(input int n);
    int k;
    k = 0;
    repeat (2) @(negedge clk);
    while (rises < n && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rise_reached", 32'(rises >= n), 32'd1);
  endtask

  vec_t   vecs[10];
  frame_t f;
  bit     ok;
  int     nrx, k;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ncs", 32'(ncs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_copi", 32'(copi), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx", {15'd0, rx_valid, rx_data}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_rst", 32'(tx_ready), 32'd1);

    vecs[0] = '{16'hA5C3, 1'b0, 16'h0000, 16'hA5C3};
    vecs[1] = '{16'h1234, 1'b1, 16'h5A3C, 16'h5A3C};
    vecs[2] = '{16'h0000, 1'b0, 16'h0000, 16'h0000};
    vecs[3] = '{16'hFFFF, 1'b1, 16'h0001, 16'h0001};
    for (int i = 4; i < 10; i++) begin
      vecs[i].tx   = 16'($urandom);
      vecs[i].sel  = 1'($urandom_range(0, 1));
      vecs[i].word = 16'($urandom);
      vecs[i].exp_rx = vecs[i].sel ? vecs[i].word : vecs[i].tx;
    end

    for (int i = 0; i < 10; i++) begin
      cipo_sel = vecs[i].sel;
      pat = vecs[i].word;
      nrx = rx_q.size();
      send(vecs[i].tx);
      wait_frame(1, ok);
      if (ok) begin
        f = frame_q.pop_front();
        check($sformatf("v%0d_ncs_low", i), 32'(f.low), 32'(LOW_T));
        check($sformatf("v%0d_rises", i), 32'(f.rises), 32'(FB));
        check($sformatf("v%0d_copi", i), {16'd0, f.bits}, {16'd0, vecs[i].tx});
        check($sformatf("v%0d_phase", i), 32'(f.phase_bad), 32'd0);
        check($sformatf("v%0d_rxv_at_ncs_rise", i), 32'(f.rxv), 32'd1);
        check($sformatf("v%0d_rx_pulses", i), 32'(rx_q.size()), 32'(nrx + 1));
        if (rx_q.size() > 0) check($sformatf("v%0d_rx_data", i), {16'd0, rx_q[$]}, {16'd0, vecs[i].exp_rx});
      end
    end

    // Back-to-back with tx_valid held; data swapped right after the first handshake.
    cipo_sel = 1'b0;
    wait_ready("b2b_ready1");
    tx_data = 16'h0102;
    tx_valid = 1'b1;
    @(posedge clk);
    #1 tx_data = 16'h0304;
    wait_ready("b2b_ready2");
    @(posedge clk);
    #1 tx_valid = 1'b0;
    wait_frame(2, ok);
    if (ok) begin
      f = frame_q.pop_front();
      check("b2b_first", {16'd0, f.bits}, 32'h0102);
      f = frame_q.pop_front();
      check("b2b_second", {16'd0, f.bits}, 32'h0304);
      check("b2b_gap", 32'(gap_q[$]), 32'(GP + 1));
    end
    check("ready_only_idle", 32'(txr_bad), 32'd0);

    // Request during a frame is dropped.
    send(16'h1234);
    wait_rises(5);
    tx_data = 16'hFFFF;
    tx_valid = 1'b1;
    @(negedge clk);
    check("busy_ready_low", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    wait_frame(1, ok);
    if (ok) begin
      f = frame_q.pop_front();
      check("busy_sent", {16'd0, f.bits}, 32'h1234);
      if (rx_q.size() > 0) check("busy_rx", {16'd0, rx_q[$]}, 32'h1234);
    end
    repeat (40) @(negedge clk);
    check("busy_no_second", 32'(frame_q.size()), 32'd0);
    check("busy_idle_ncs", {30'd0, ncs, busy}, 32'h2);

    // Reset after the 7th rise abandons the frame.
    nrx = rx_q.size();
    send(16'hC3C3);
    wait_rises(7);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_ncs", 32'(ncs), 32'd1);
    check("rst_mid_sclk", 32'(sclk), 32'd0);
    check("rst_mid_copi", 32'(copi), 32'd0);
    check("rst_mid_rx", {15'd0, rx_valid, rx_data}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_mid_no_rxv", 32'(rx_q.size()), 32'(nrx));
    check("rst_mid_no_frame", 32'(frame_q.size()), 32'd0);
    send(16'h00FF);
    wait_frame(1, ok);
    if (ok) begin
      f = frame_q.pop_front();
      check("after_rst_copi", {16'd0, f.bits}, 32'h00FF);
      check("after_rst_low", 32'(f.low), 32'(LOW_T));
      if (rx_q.size() > 0) check("after_rst_rx", {16'd0, rx_q[$]}, 32'h00FF);
    end

    // Minimum-timing instance driving the peripheral model.
    k = 0;
    while (!tx_ready2 && k < 500) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    tx_data2 = 16'h12AB;
    tx_valid2 = 1'b1;
    @(posedge clk);
    #1 tx_valid2 = 1'b0;
    k = 0;
    while (done2 == 0 && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("corner_done", 32'(done2), 32'd1);
    check("corner_upper", {24'd0, per_upper}, 32'h12);
    check("corner_lower", {24'd0, per_lower}, 32'hAB);
    check("corner_ncs_low", 32'(low2_last), 32'd66);
    check("corner_rx", {16'd0, rx_data2}, 32'h12AB);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule
